// File: rtl/aib_rxdp_wm_align.sv
// Read-domain word-marker aligner: hunts the half-word phase from the per-half
// marker bits, locks it, and emits 78-bit marker-stripped words.

module aib_rxdp_wm_align_chk (
  input logic rx_clock_fifo_rd_clk,
  input logic rx_reset_fifo_rd_rst_n,
  input logic dout_vld,
  input logic align_lock,
  input logic align_err
);

  // The unlock pulse never coincides with valid data or a lock indication
  a_err_exclusive : assert property (
    @(posedge rx_clock_fifo_rd_clk) disable iff (!rx_reset_fifo_rd_rst_n)
    align_err |-> (!dout_vld && !align_lock)
  );

endmodule

module aib_rxdp_wm_align #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3
) (
  input  logic        rx_clock_fifo_rd_clk,
  input  logic        rx_reset_fifo_rd_rst_n,
  input  logic [79:0] din,
  input  logic        din_vld,
  input  logic        r_wm_en,
  output logic [77:0] dout,
  output logic        dout_vld,
  output logic        align_lock,
  output logic        align_phase,
  output logic        align_err
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] LOCK_CNT_C   = 5'(LOCK_CNT);
  localparam logic [4:0] UNLOCK_CNT_C = 5'(UNLOCK_CNT);

  function automatic logic [3:0] sat_inc(input logic [4:0] sum);
    return sum[4] ? 4'hF : sum[3:0];
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  gcnt_r;
  logic [3:0]  gcnt_nxt_s;
  logic [3:0]  ecnt_r;
  logic [3:0]  ecnt_nxt_s;
  logic        phase_r;
  logic        phase_nxt_s;
  logic        err_nxt_s;
  // Only the data bits of the previous lower half are ever forwarded
  logic [38:0] prev_r;
  logic [1:0]  mk_s;
  logic [1:0]  pat_s;
  logic        match_s;
  logic [4:0]  gcnt_inc_s;
  logic [4:0]  ecnt_inc_s;
  logic [77:0] aligned_s;
  logic        vld_nxt_s;
  logic [77:0] dout_r;
  logic        dout_vld_r;
  logic        align_lock_r;
  logic        align_phase_r;
  logic        align_err_r;

  // Marker decode and next-state / counter evaluation
  always_comb begin
    mk_s        = {din[79], din[39]};
    pat_s       = phase_r ? 2'b01 : 2'b10;
    match_s     = din_vld && (mk_s == pat_s);
    gcnt_inc_s  = {1'b0, gcnt_r} + 5'd1;
    ecnt_inc_s  = {1'b0, ecnt_r} + 5'd1;
    state_nxt_s = state_r;
    gcnt_nxt_s  = gcnt_r;
    ecnt_nxt_s  = ecnt_r;
    phase_nxt_s = phase_r;
    err_nxt_s   = 1'b0;
    if (!r_wm_en) begin
      state_nxt_s = HUNT;
      gcnt_nxt_s  = 4'd0;
      ecnt_nxt_s  = 4'd0;
      phase_nxt_s = 1'b0;
    end else if (din_vld) begin
      case (state_r)
        HUNT: begin
          if ((mk_s == 2'b10) || (mk_s == 2'b01)) begin
            phase_nxt_s = mk_s[0];
            gcnt_nxt_s  = 4'd1;
            state_nxt_s = (LOCK_CNT_C == 5'd1) ? LOCKED : VERIFY;
          end else begin
            state_nxt_s = HUNT;
          end
        end
        VERIFY: begin
          if (match_s) begin
            gcnt_nxt_s  = sat_inc(gcnt_inc_s);
            state_nxt_s = (gcnt_inc_s == LOCK_CNT_C) ? LOCKED : VERIFY;
          end else begin
            // The breaking word is dropped, not retried as a HUNT candidate
            state_nxt_s = HUNT;
            gcnt_nxt_s  = 4'd0;
          end
        end
        LOCKED: begin
          if (match_s) begin
            ecnt_nxt_s = 4'd0;
          end else if (ecnt_inc_s == UNLOCK_CNT_C) begin
            state_nxt_s = HUNT;
            gcnt_nxt_s  = 4'd0;
            ecnt_nxt_s  = 4'd0;
            err_nxt_s   = 1'b1;
          end else begin
            ecnt_nxt_s = sat_inc(ecnt_inc_s);
          end
        end
        default: begin
          state_nxt_s = HUNT;
          gcnt_nxt_s  = 4'd0;
          ecnt_nxt_s  = 4'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Half-word alignment and output qualifier
  always_comb begin
    if (r_wm_en && phase_nxt_s) begin
      aligned_s = {prev_r, din[78:40]};
    end else begin
      aligned_s = {din[78:40], din[38:0]};
    end
    if (r_wm_en) begin
      vld_nxt_s = din_vld && (state_nxt_s == LOCKED);
    end else begin
      vld_nxt_s = din_vld;
    end
  end

  // FSM state, counters, previous-half register and registered outputs
  always_ff @(posedge rx_clock_fifo_rd_clk or negedge rx_reset_fifo_rd_rst_n) begin
    if (!rx_reset_fifo_rd_rst_n) begin
      state_r       <= HUNT;
      gcnt_r        <= 4'd0;
      ecnt_r        <= 4'd0;
      phase_r       <= 1'b0;
      prev_r        <= 39'd0;
      dout_r        <= 78'd0;
      dout_vld_r    <= 1'b0;
      align_lock_r  <= 1'b0;
      align_phase_r <= 1'b0;
      align_err_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      gcnt_r        <= gcnt_nxt_s;
      ecnt_r        <= ecnt_nxt_s;
      phase_r       <= phase_nxt_s;
      dout_vld_r    <= vld_nxt_s;
      align_lock_r  <= (state_nxt_s == LOCKED);
      align_phase_r <= phase_nxt_s;
      align_err_r   <= err_nxt_s;
      if (din_vld) begin
        prev_r <= din[38:0];
        dout_r <= aligned_s;
      end else begin
        prev_r <= prev_r;
        dout_r <= dout_r;
      end
    end
  end

  assign dout        = dout_r;
  assign dout_vld    = dout_vld_r;
  assign align_lock  = align_lock_r;
  assign align_phase = align_phase_r;
  assign align_err   = align_err_r;

  aib_rxdp_wm_align_chk u_chk (
    .rx_clock_fifo_rd_clk   (rx_clock_fifo_rd_clk),
    .rx_reset_fifo_rd_rst_n (rx_reset_fifo_rd_rst_n),
    .dout_vld               (dout_vld_r),
    .align_lock             (align_lock_r),
    .align_err              (align_err_r)
  );

endmodule
